// File: rtl/exmem_pkg.sv
// exmem_pkg: shared control bit map, default widths, payload and state types for the EX/MEM stage
package exmem_pkg;
  localparam int EXMEM_DATA_W = 32;
  localparam int EXMEM_RD_W = 4;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_CNT_W = 16;
  localparam int CTRL_DATAINPUTON = 0;
  localparam int CTRL_RWRITE = 1;
  localparam int CTRL_WE = 2;
  localparam int CTRL_DATAINPUTS = 3;
  localparam int CTRL_SELECTMEM = 4;
  typedef struct packed {
    logic [EXMEM_DATA_W-1:0] alu_result;
    logic [EXMEM_DATA_W-1:0] data2;
    logic [EXMEM_DATA_W-1:0] inst;
    logic [EXMEM_RD_W-1:0] rd;
    logic [EXMEM_CTRL_W-1:0] ctrl;
  } exmem_payload_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: valid/ready buffer with optional skid entry so in_ready can come straight from a flop
module pipe_skid_buf import exmem_pkg::*; #(
  parameter int W = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  state_t state;
  logic [W-1:0] main_q, skid_q;
  logic accept, consume;
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  assign in_ready = SKID ? state != TWO : !out_valid | out_ready;
  assign accept = in_valid & in_ready & !flush;
  assign consume = out_valid & out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          main_q <= in_data;
          state <= ONE;
        end
        ONE: if (accept & consume) begin
          main_q <= in_data;
        end else if (accept & SKID) begin
          skid_q <= in_data;
          state <= TWO;
        end else if (consume) begin
          state <= EMPTY;
        end
        TWO: if (consume) begin
          main_q <= skid_q;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/exmem_pipe_stage.sv
// exmem_pipe_stage: handshaked EX->MEM register; bubbles never carry control, stall cycles are counted
module exmem_pipe_stage import exmem_pkg::*; #(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int RD_W = EXMEM_RD_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter bit SKID = 1'b1,
  parameter int CNT_W = EXMEM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_inst,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] inst;
    logic [RD_W-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;
  payload_t in_p, out_p;
  assign in_p = {in_alu_result, in_data2, in_inst, in_rd, in_ctrl};
  pipe_skid_buf #(.W($bits(payload_t)), .SKID(SKID)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_p)
  );
  assign out_alu_result = out_p.alu_result;
  assign out_data2 = out_p.data2;
  assign out_inst = out_p.inst;
  assign out_rd = out_p.rd;
  assign out_ctrl = out_p.ctrl & {CTRL_W{out_valid}};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (out_valid & !out_ready & stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: doc/exmem_pipe_stage.md
Name: exmem_pipe_stage

Overview:
Parametrised EX→MEM pipeline stage register. It replaces the fixed always-loading register with a valid/ready handshaked stage that supports stall (backpressure), flush (bubble insertion) and an optional one-entry skid buffer for full throughput under registered ready. The stage sits between the execute-stage ALU and the data-memory/write-back path. Control bits are gated by valid, so a bubble can never write memory or the register file.

Parameters:
DATA_W, 32, width of ALU result, store data (Data2) and instruction words
RD_W, 4, destination register index width
CTRL_W, 5, control bundle width; bit map in exmem_pkg
SKID, 1, 1 = two-entry stage with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  stage clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries and of any same-cycle input
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept this cycle
in_alu_result  in  DATA_W  ALU result
in_data2  in  DATA_W  store data
in_inst  in  DATA_W  instruction word
in_rd  in  RD_W  destination register
in_ctrl  in  CTRL_W  {SelectMem, DataInputS, we, RWrite, DataInputON} (bit 4..0)
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes this cycle
out_alu_result / out_data2 / out_inst  out  DATA_W  held payload
out_rd  out  RD_W  held destination
out_ctrl  out  CTRL_W  held control, forced 0 when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (async, any cycle, including mid-transfer): out_valid=0, skid entry empty, all payload registers 0, out_ctrl=0, stall_cnt=0. in_ready=1 from the first edge after reset deassertion; in SKID=1 it is driven from the registered state.
- accept = in_valid & in_ready & !flush; consume = out_valid & out_ready.
- Latency: an accepted beat appears on out_* the next cycle. Throughput: 1 beat/cycle while out_ready=1.
- Payload on out_* must not change while out_valid=1 and out_ready=0.
- States (SKID=1): EMPTY (main and skid empty), ONE (main full), TWO (main and skid full).
- EMPTY: accept → ONE, main loads input.
- ONE: accept&consume → ONE, main loads input. accept&!consume → TWO, skid loads input. !accept&consume → EMPTY. Otherwise hold.
- TWO: consume → ONE, main loads skid. Otherwise hold.
- in_ready = (state != TWO) in SKID=1. It is a register output with no combinational path from out_ready.
- SKID=0: only EMPTY and ONE exist; in_ready = !out_valid | out_ready (combinational).
- flush=1: next state EMPTY regardless of accept/consume. Same-cycle input is discarded, and same-cycle consume is still a valid handshake for the downstream side. Payload registers keep stale data; only valid bits clear.
- out_ctrl = ctrl_q & {CTRL_W{out_valid}}. Bubbles carry zero we/RWrite.
- stall_cnt increments by 1 in each cycle with out_valid & !out_ready and saturates at 2^CNT_W−1. It is cleared only by reset; flush does not clear it.

Decomposition:
- exmem_pkg: ctrl bit index constants (CTRL_DATAINPUTON=0, CTRL_RWRITE=1, CTRL_WE=2, CTRL_DATAINPUTS=3, CTRL_SELECTMEM=4), a packed payload struct typedef, and a state enum {EMPTY, ONE, TWO}.
- One sub-module: pipe_skid_buf. It is a generic, payload-width-parametrised handshake buffer holding the state machine and both entries. exmem_pipe_stage packs and unpacks fields, applies ctrl gating and owns stall_cnt.

Test Plan:
- Reset asserted mid-stream with out_valid=1 → same-cycle out_valid=0, out_ctrl=0, stall_cnt=0, out_alu_result=0, without waiting for a clk edge.
- out_ready=1; stream A=0x11, B=0x22, C=0x33 on consecutive cycles → out_alu_result 0x11, 0x22, 0x33 one cycle later each; in_ready stays 1.
- out_ready=0; send A, then B → A held on out_*, B in skid, in_ready=0, stall_cnt counts; raise out_ready → A then B on consecutive cycles, in_ready returns to 1.
- In state TWO with in_ctrl we=1 on both entries, pulse flush → next cycle out_valid=0, out_ctrl=0, in_ready=1; neither entry ever emitted.
- CNT_W=3, out_ready=0 for 10 cycles with out_valid=1 → stall_cnt saturates at 7.
- SKID=0 build, out_ready=0 with A held → in_ready=0; out_ready=1 and in_valid=1 same cycle → B replaces A with no bubble.
